branch_pred: RTL and testbench
==============================

BRANCH_PRED -- requirements
Module: branch_pred

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and PC width.
REQ-002 SHALL have parameter ENTRIES, default 16, number of BTB/BHT entries (power of two, >=2); IDX_W = log2(ENTRIES).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port pc_f  input  XLEN  fetch-stage PC to look up.
REQ-006 SHALL have port pred_taken_f  output  1  predicted taken for pc_f.
REQ-007 SHALL have port pred_target_f  output  XLEN  predicted target; equals pc_f+4 when pred_taken_f=0.
REQ-008 SHALL have port upd_valid_e  input  1  execute-stage instruction valid (not flushed).
REQ-009 SHALL have port upd_pc_e  input  XLEN  PC of execute-stage instruction.
REQ-010 SHALL have port upd_is_br_e  input  1  execute instruction is branch/jal/jalr.
REQ-011 SHALL have port upd_taken_e  input  1  resolved outcome (br_en).
REQ-012 SHALL have port upd_target_e  input  XLEN  resolved target (ALU result).
REQ-013 SHALL have port upd_pred_taken_e  input  1  prediction carried down the pipeline with the instruction.
REQ-014 SHALL have port upd_pred_target_e  input  XLEN  predicted target carried down the pipeline.
REQ-015 SHALL have port mispredict_e  output  1  flush F/D and redirect fetch.
REQ-016 SHALL have port redirect_pc_e  output  XLEN  correct next PC on mispredict.

Function
REQ-017 SHALL use index = pc[IDX_W+1:2] and tag = pc[XLEN-1:IDX_W+2]; each entry holds valid, tag, target, 2-bit counter.
REQ-018 SHALL compute the lookup combinationally (zero latency): hit = valid & tag match; pred_taken_f = hit & counter[1]; pred_target_f = pred_taken_f ? entry target : pc_f+4.
REQ-019 SHALL write an entry only on a rising edge with upd_valid_e=1 and upd_is_br_e=1.
REQ-020 SHALL on update miss (invalid or tag mismatch) allocate/replace: valid=1, tag, target=upd_target_e, counter = upd_taken_e ? 2'b10 : 2'b01.
REQ-021 SHALL on update hit saturate the counter: increment on taken (max 2'b11), decrement on not-taken (min 2'b00); overwrite target only when taken.
REQ-022 SHALL invalidate the indexed entry when upd_valid_e=1, upd_is_br_e=0 and that entry hits (alias cleanup).
REQ-023 SHALL drive mispredict_e = upd_valid_e & ((upd_pred_taken_e != taken_eff) | (taken_eff & upd_pred_target_e != upd_target_e)), where taken_eff = upd_is_br_e & upd_taken_e.
REQ-024 SHALL drive redirect_pc_e = taken_eff ? upd_target_e : upd_pc_e+4, combinationally.
REQ-025 SHALL, when lookup and update hit the same index in one cycle, return the pre-update contents; the update is visible on the next cycle.
REQ-026 SHALL hold all state unchanged when upd_valid_e=0.
REQ-027 SHALL wrap PC+4 modulo 2^XLEN.

Reset
REQ-028 SHALL on rst=1 at a rising edge clear all valid bits and set all counters to 2'b01, overriding any simultaneous update.
REQ-029 SHALL give pred_taken_f=0 and pred_target_f=pc_f+4 on the first cycle after reset; mispredict_e and redirect_pc_e remain purely combinational from their inputs.

Configuration
REQ-030 SHALL, when BP_STATS_EN is defined, add outputs lookup_cnt and mispred_cnt (32 bits each), reset to 0. lookup_cnt increments every non-reset cycle. mispred_cnt increments each cycle with mispredict_e=1. Both wrap at 2^32.
REQ-031 SHALL, without BP_STATS_EN, omit both ports and counters; all other behaviour is identical.

Verification
REQ-032 SHALL cover: reset, then pc_f=0x40 -> pred_taken_f=0, pred_target_f=0x44.
REQ-033 SHALL cover: update pc=0x40 taken target=0x80, pred_taken=0 -> mispredict_e=1, redirect=0x80; next cycle pc_f=0x40 -> taken, target 0x80.
REQ-034 SHALL cover: two not-taken updates at 0x40 after REQ-033 -> counter 10->01->00; lookup not-taken; redirect=0x44 on the first.
REQ-035 SHALL cover: ENTRIES=16, update 0x40 then 0x80 (same index, different tag) -> 0x40 misses, 0x80 hits.
REQ-036 SHALL cover: same-cycle lookup/update at 0x40 -> old prediction returned that cycle, new one next cycle; rst asserted with upd_valid_e=1 -> table cleared, no write.
REQ-037 SHALL cover: non-branch update at a hitting PC with pred_taken=1 -> mispredict_e=1, redirect=pc+4, entry invalidated; with BP_STATS_EN, mispred_cnt increments by 1.

Source files
------------

// File: rtl/branch_pred.sv
// branch_pred: direct-mapped BTB with per-entry 2-bit saturating counters.
// The fetch stage looks up the table in the same cycle. The execute stage resolves
// the branch, signals a mispredict, and trains the table.
// Optional feature: define BP_STATS_EN to add the lookup_cnt and mispred_cnt
// statistics outputs.
module branch_pred #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_target_f,
  input  logic            upd_valid_e,
  input  logic [XLEN-1:0] upd_pc_e,
  input  logic            upd_is_br_e,
  input  logic            upd_taken_e,
  input  logic [XLEN-1:0] upd_target_e,
  input  logic            upd_pred_taken_e,
  input  logic [XLEN-1:0] upd_pred_target_e,
  output logic            mispredict_e,
  output logic [XLEN-1:0] redirect_pc_e
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     lookup_cnt,
  output logic [31:0]     mispred_cnt
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit, taken_eff;

  assign f_idx = pc_f[IDX_W+1:2];
  assign f_tag = pc_f[XLEN-1:IDX_W+2];
  assign e_idx = upd_pc_e[IDX_W+1:2];
  assign e_tag = upd_pc_e[XLEN-1:IDX_W+2];

  // Fetch lookup reads only registered state, so a same-cycle update shows up next cycle.
  always_comb begin
    f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken_f  = f_hit && ctr_q[f_idx][1];
    pred_target_f = pred_taken_f ? target_q[f_idx] : pc_f + XLEN'(4);
  end

  // Execute-stage resolution: mispredict detection and the correct next fetch PC.
  always_comb begin
    taken_eff     = upd_is_br_e && upd_taken_e;
    mispredict_e  = upd_valid_e &&
                    ((upd_pred_taken_e != taken_eff) ||
                     (taken_eff && (upd_pred_target_e != upd_target_e)));
    redirect_pc_e = taken_eff ? upd_target_e : upd_pc_e + XLEN'(4);
  end

  // Next table contents: allocate on a miss, train on a hit, drop a non-branch alias.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned and infers a latch.
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    e_hit    = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    if (upd_valid_e) begin
      if (upd_is_br_e) begin
        if (!e_hit) begin
          valid_d[e_idx]  = 1'b1;
          tag_d[e_idx]    = e_tag;
          target_d[e_idx] = upd_target_e;
          ctr_d[e_idx]    = upd_taken_e ? 2'b10 : 2'b01;
        end else if (upd_taken_e) begin
          target_d[e_idx] = upd_target_e;
          if (ctr_q[e_idx] != 2'b11) ctr_d[e_idx] = ctr_q[e_idx] + 2'b01;
        end else begin
          if (ctr_q[e_idx] != 2'b00) ctr_d[e_idx] = ctr_q[e_idx] - 2'b01;
        end
      end else if (e_hit) begin
        valid_d[e_idx] = 1'b0;
      end
    end
  end

  // Valid bits and counters: reset has priority over any simultaneous update.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tag and target storage: no reset is needed because a clear valid bit masks the contents.
  always_ff @(posedge clk) begin
    // NOTE: the data arrays are deliberately left unreset. This keeps them plain RAM, and valid_q guards them.
    if (!rst) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] lookup_cnt_q, lookup_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // Statistics counters wrap naturally at 2^32.
  always_comb begin
    lookup_cnt_d  = lookup_cnt_q + 32'd1;
    mispred_cnt_d = mispred_cnt_q + {31'd0, mispredict_e};
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      lookup_cnt_q  <= lookup_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign lookup_cnt  = lookup_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_pred.sv
// tb_branch_pred: directed and random stimulus for branch_pred. A table-level
// behavioural model predicts the outputs and is compared every cycle.
module tb_branch_pred;
  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [XLEN-1:0] pc_f = '0;
  logic            pred_taken_f;
  logic [XLEN-1:0] pred_target_f;
  logic            upd_valid_e = 1'b0;
  logic [XLEN-1:0] upd_pc_e = '0;
  logic            upd_is_br_e = 1'b0;
  logic            upd_taken_e = 1'b0;
  logic [XLEN-1:0] upd_target_e = '0;
  logic            upd_pred_taken_e = 1'b0;
  logic [XLEN-1:0] upd_pred_target_e = '0;
  logic            mispredict_e;
  logic [XLEN-1:0] redirect_pc_e;
`ifdef BP_STATS_EN
  logic [31:0]     lookup_cnt, mispred_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  branch_pred #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst(rst), .pc_f(pc_f),
    .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
    .upd_valid_e(upd_valid_e), .upd_pc_e(upd_pc_e), .upd_is_br_e(upd_is_br_e),
    .upd_taken_e(upd_taken_e), .upd_target_e(upd_target_e),
    .upd_pred_taken_e(upd_pred_taken_e), .upd_pred_target_e(upd_pred_target_e),
    .mispredict_e(mispredict_e), .redirect_pc_e(redirect_pc_e)
`ifdef BP_STATS_EN
    , .lookup_cnt(lookup_cnt), .mispred_cnt(mispred_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: one record per table slot, counter kept as an integer 0..3.
  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  int unsigned m_lookups  = 0;
  int unsigned m_mispreds = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
    int i;
    i  = idx_of(pc);
    tk = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
    tg = tk ? m_target[i] : pc + 32'd4;
  endfunction

  function automatic logic m_mispredict();
    logic te;
    te = upd_is_br_e && upd_taken_e;
    return upd_valid_e && ((upd_pred_taken_e != te) || (te && (upd_pred_target_e != upd_target_e)));
  endfunction

  function automatic logic [31:0] m_redirect();
    return (upd_is_br_e && upd_taken_e) ? upd_target_e : upd_pc_e + 32'd4;
  endfunction

  // Model state update at each rising edge, using the inputs held over the previous cycle.
  always @(posedge clk) begin
    int  i;
    bit  hit;
    if (rst) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 1;
      end
      m_lookups  = 0;
      m_mispreds = 0;
    end else begin
      m_lookups++;
      if (m_mispredict()) m_mispreds++;
      if (upd_valid_e) begin
        i   = idx_of(upd_pc_e);
        hit = m_valid[i] && (m_tag[i] == tag_of(upd_pc_e));
        if (upd_is_br_e) begin
          if (!hit) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = tag_of(upd_pc_e);
            m_target[i] = upd_target_e;
            m_ctr[i]    = upd_taken_e ? 2 : 1;
          end else if (upd_taken_e) begin
            m_target[i] = upd_target_e;
            m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          end else begin
            m_ctr[i]    = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
          end
        end else if (hit) begin
          m_valid[i] = 1'b0;
        end
      end
    end
  end

  // Mid-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic        etk;
    logic [31:0] etg;
    if (chk_en) begin
      m_lookup(pc_f, etk, etg);
      check("pred_taken_f", 64'(pred_taken_f), 64'(etk));
      check("pred_target_f", 64'(pred_target_f), 64'(etg));
      check("mispredict_e", 64'(mispredict_e), 64'(m_mispredict()));
      check("redirect_pc_e", 64'(redirect_pc_e), 64'(m_redirect()));
`ifdef BP_STATS_EN
      check("lookup_cnt", 64'(lookup_cnt), 64'(m_lookups));
      check("mispred_cnt", 64'(mispred_cnt), 64'(m_mispreds));
`endif
    end
  end

  task automatic drive(input logic r, input logic [31:0] pcf, input logic uv,
                       input logic [31:0] upc, input logic br, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    @(posedge clk);
    #1;
    rst = r; pc_f = pcf; upd_valid_e = uv; upd_pc_e = upc; upd_is_br_e = br;
    upd_taken_e = tk; upd_target_e = tgt; upd_pred_taken_e = ptk; upd_pred_target_e = ptgt;
    #2;
  endtask

  task automatic idle(input logic [31:0] pcf);
    drive(1'b0, pcf, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(7) == 0) return $urandom;
    return (32'($urandom_range(3)) << 6) | (32'($urandom_range(15)) << 2);
  endfunction

  initial begin
    logic [31:0] upc, tgt, ptg, mtg;
    logic        mtk, ptk;

    // Reset held while an update is presented: the update must not land.
    drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 32'h44);
    chk_en = 1'b1;
    drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 32'h44);

    idle(32'h40);
    check("post_reset_taken", 64'(pred_taken_f), 64'd0);
    check("post_reset_target", 64'(pred_target_f), 64'h44);

    drive(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 32'h44);
    check("alloc_mispredict", 64'(mispredict_e), 64'd1);
    check("alloc_redirect", 64'(redirect_pc_e), 64'h80);
    check("alloc_same_cycle_old", 64'(pred_taken_f), 64'd0);

    idle(32'h40);
    check("trained_taken", 64'(pred_taken_f), 64'd1);
    check("trained_target", 64'(pred_target_f), 64'h80);

    drive(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 1'b1, 32'h80);
    check("nt1_mispredict", 64'(mispredict_e), 64'd1);
    check("nt1_redirect", 64'(redirect_pc_e), 64'h44);
    check("nt1_same_cycle_old", 64'(pred_taken_f), 64'd1);

    drive(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 1'b0, 32'h44);
    check("nt2_mispredict", 64'(mispredict_e), 64'd0);
    check("nt2_new_prediction", 64'(pred_taken_f), 64'd0);

    idle(32'h40);
    check("ctr00_taken", 64'(pred_taken_f), 64'd0);
    check("ctr00_target", 64'(pred_target_f), 64'h44);

    drive(1'b0, 32'h40, 1'b1, 32'h80, 1'b1, 1'b1, 32'h200, 1'b0, 32'h84);
    check("alias_redirect", 64'(redirect_pc_e), 64'h200);
    idle(32'h40);
    check("alias_old_miss", 64'(pred_taken_f), 64'd0);
    idle(32'h80);
    check("alias_new_hit", 64'(pred_taken_f), 64'd1);
    check("alias_new_target", 64'(pred_target_f), 64'h200);

    drive(1'b0, 32'h80, 1'b1, 32'h80, 1'b0, 1'b0, 32'h1234, 1'b1, 32'h200);
    check("nonbr_mispredict", 64'(mispredict_e), 64'd1);
    check("nonbr_redirect", 64'(redirect_pc_e), 64'h84);
    idle(32'h80);
    check("nonbr_invalidated", 64'(pred_taken_f), 64'd0);
    check("nonbr_inv_target", 64'(pred_target_f), 64'h84);

    drive(1'b0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("wrap_pred_target", 64'(pred_target_f), 64'h0);
    check("wrap_redirect", 64'(redirect_pc_e), 64'h0);

    drive(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 1'b0, 32'h44);
    drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80);
    check("pre_reset_hit", 64'(pred_taken_f), 64'd1);
    idle(32'h40);
    check("reset_cleared", 64'(pred_taken_f), 64'd0);

    // Random phase: a small PC pool so entries hit, alias and retrain often.
    for (int n = 0; n < 3000; n++) begin
      upc = rand_pc();
      tgt = rand_pc() & 32'hFFFF_FFFC;
      m_lookup(upc, mtk, mtg);
      if ($urandom_range(1) == 1) begin
        ptk = mtk; ptg = mtg;
      end else begin
        ptk = 1'($urandom_range(1)); ptg = ($urandom_range(1) == 1) ? tgt : rand_pc();
      end
      drive(($urandom_range(199) == 0), rand_pc(), 1'($urandom_range(1)), upc,
            ($urandom_range(3) != 0), 1'($urandom_range(1)), tgt, ptk, ptg);
    end

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
